key_event_scheduler: RTL and testbench
======================================

# key_event_scheduler

Multi-key press scheduler for the piano front end. It classifies each of `N_KEYS` synchronized key levels into short-press and long-press events, holds at most one pending event per key, and shares a single event output port between all keys using a round-robin arbiter with a valid/ready handshake. It sits between the key synchronizers and the game/note logic, which consumes one event at a time.

## Interface
- `N_KEYS`, default 8: number of key inputs, 2..16.
- `CNT_W`, default 8: press-counter width; `LONG_TH` < 2**`CNT_W`.
- `LONG_TH`, default 100: hold cycles that make a press long.
- `MIN_TH`, default 2: presses shorter than this are glitches and are ignored; 1 ≤ `MIN_TH` < `LONG_TH`.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `key_in`  in  N_KEYS  synchronized key levels, 1 = pressed.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_key`  out  $clog2(N_KEYS)  index of the key that produced the event.
- `evt_long`  out  1  0 = short press, 1 = long press.
- `evt_drop`  out  1  one-cycle pulse: a new event was lost because its key's slot was full.

## Operation
- Per key, `cnt` increments while `key_in` is high and saturates at `LONG_TH`. It clears to 0 whenever `key_in` is low. It never wraps.
- Long event: raised on the cycle `key_in` is high and `cnt == LONG_TH-1`, i.e. exactly once per hold. It fires before release.
- Short event: raised on the cycle `key_in` is low, the previous sample was high, and `MIN_TH ≤ cnt < LONG_TH`.
- Releasing after a long press raises nothing. A press with `cnt < MIN_TH` raises nothing.
- Pending slot per key holds {pend, kind}. A raised event sets the slot at the next edge.
- If the slot is already pending and is not being granted in the same cycle, the new event is discarded, the slot keeps the old event, and `evt_drop` pulses. Grant and set in the same cycle: the slot takes the new event, with no drop.
- The output register is loadable when `evt_valid == 0` or `evt_valid && evt_ready`.
- When loadable, the scheduler searches for a pending key starting at `last_grant+1` modulo `N_KEYS`. The first hit is loaded into `evt_key`/`evt_long`, its slot clears, and `last_grant` updates. If no slot is pending, `evt_valid` drops to 0.
- States: IDLE (`evt_valid=0`) and HOLD (`evt_valid=1`).
  - IDLE→HOLD when any slot is pending.
  - HOLD→HOLD on accept with another slot pending, or while `evt_ready=0`.
  - HOLD→IDLE on accept with no slot pending.
- Handshake: while `evt_valid && !evt_ready`, `evt_key` and `evt_long` stay stable.
- Reset values:
  - `evt_valid`=0, `evt_key`=0, `evt_long`=0, `evt_drop`=0.
  - All counters, previous samples and slots are 0.
  - `last_grant`=`N_KEYS-1`, so key 0 has first priority.
- Reset mid-press discards all progress. A key still held after reset deasserts is counted from 0.

## Timing
- Event condition true in cycle t → slot set at edge t+1 → `evt_valid` high after edge t+2 if the output is free.
- Throughput: one event per cycle while `evt_ready=1`.
- `evt_drop` is registered and is high for the single cycle after the discarding edge.
- All outputs are registered; there is no combinational path from `evt_ready` to `evt_valid`.

## Structure
- Shared package `bnw_pkg`:
  - `EVT_SHORT`=1'b0 and `EVT_LONG`=1'b1.
  - An event struct {key, long}.
- Sub-module `key_press_classifier`, one instance per key via generate. It holds `cnt` and the previous sample and outputs one-cycle `short_evt`/`long_evt` pulses.
- Slots, the round-robin arbiter and the output register stay in the top module.

## Test plan
- Key 2 high 5 cycles then low, `evt_ready`=1 → exactly one event, `evt_key`=2, `evt_long`=0, `evt_valid` high 2 cycles after the first low cycle.
- Key 0 held 150 cycles → one event `evt_key`=0, `evt_long`=1, `evt_valid` asserted 2 cycles after the 100th high cycle; nothing on release.
- Key 5 high for 1 cycle (`MIN_TH`=2) → no event, no drop.
- Keys 1, 3, 5 released on the same cycle, `evt_ready`=1 → events 1, 3, 5 on consecutive cycles. Then key 1 and key 6 pending together → 6 is served before 1 (`last_grant`=5).
- `evt_ready`=0, key 4 gives three short presses → first event held stable in the output register, second pending in the slot, third discarded with a 1-cycle `evt_drop`. Raising `evt_ready` then delivers exactly two events for key 4.
- `rst` asserted while key 7 is at `cnt`=60 and an event is held → outputs go to 0 immediately. After release of `rst`, 100 more high cycles are needed before key 7's long event.

Source files
------------

// File: rtl/bnw_pkg.sv
// Shared definitions for the key event scheduler: event kinds and the event record.
package bnw_pkg;
    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // Key field sized for the largest supported keyboard (16 keys).
    localparam int KEY_W_MAX = 4;

    typedef struct packed {
        logic [KEY_W_MAX-1:0] key;
        logic                 long;
    } evt_t;
endpackage

// File: rtl/key_event_scheduler_if.sv
// Event port between the scheduler and its single consumer (valid/ready plus drop pulse).
interface key_event_if #(parameter int N_KEYS = 8) ();
    logic                      evt_valid;
    logic                      evt_ready;
    logic [$clog2(N_KEYS)-1:0] evt_key;
    logic                      evt_long;
    logic                      evt_drop;

    modport master (output evt_valid, evt_key, evt_long, evt_drop, input evt_ready);
    modport slave  (input evt_valid, evt_key, evt_long, evt_drop, output evt_ready);
endinterface

// File: rtl/key_press_classifier.sv
// Per-key press timer: emits a one-cycle long pulse during the hold and a short pulse on release.
module key_press_classifier #(
    parameter int CNT_W   = 8,
    parameter int LONG_TH = 100,
    parameter int MIN_TH  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic short_evt,
    output logic long_evt
);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TH);
    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TH - 1);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_TH);

    logic [CNT_W-1:0] cnt;
    logic             prev;

    // Saturating at LONG_TH makes the long pulse fire once per hold and suppresses the release event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            prev <= 1'b0;
        end else begin
            prev <= key_in;
            if (!key_in)
                cnt <= '0;
            else if (cnt != LONG_C)
                cnt <= cnt + 1'b1;
        end
    end

    assign long_evt  = key_in && (cnt == LONG_M1);
    assign short_evt = !key_in && prev && (cnt >= MIN_C) && (cnt < LONG_C);
endmodule

// File: rtl/key_event_scheduler.sv
// Per-key pending slots shared onto one registered event port through a round-robin arbiter.
module key_event_scheduler
    import bnw_pkg::*;
#(
    parameter int N_KEYS  = 8,
    parameter int CNT_W   = 8,
    parameter int LONG_TH = 100,
    parameter int MIN_TH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    key_event_if.master       evt
);
    localparam int KW = $clog2(N_KEYS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [N_KEYS-1:0] short_evt, long_evt, raise;
    logic [N_KEYS-1:0] pend, kind, grant, drop;
    logic [0:0]        state;
    logic [KW-1:0]     last_grant, sel, out_key;
    logic              out_long, drop_q, found, loadable;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        key_press_classifier #(
            .CNT_W  (CNT_W),
            .LONG_TH(LONG_TH),
            .MIN_TH (MIN_TH)
        ) u_cls (
            .clk      (clk),
            .rst      (rst),
            .key_in   (key_in[gi]),
            .short_evt(short_evt[gi]),
            .long_evt (long_evt[gi])
        );
    end

    assign raise    = short_evt | long_evt;
    assign loadable = (state == IDLE) || evt.evt_ready;

    // First pending slot after the last winner, wrapping modulo N_KEYS.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= N_KEYS; k++) begin
            idx = (int'(last_grant) + k) % N_KEYS;
            if (!found && pend[idx[KW-1:0]]) begin
                found = 1'b1;
                sel   = idx[KW-1:0];
            end
        end
        grant = '0;
        if (loadable && found)
            grant[sel] = 1'b1;
    end

    // A new event only displaces a pending one if that slot is being granted this cycle.
    assign drop = raise & pend & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            kind <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (raise[i] && !drop[i]) begin
                    pend[i] <= 1'b1;
                    kind[i] <= long_evt[i] ? EVT_LONG : EVT_SHORT;
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_key    <= '0;
            out_long   <= 1'b0;
            last_grant <= KW'(N_KEYS - 1);
            drop_q     <= 1'b0;
        end else begin
            drop_q <= |drop;
            case (state)
                IDLE: if (found) state <= HOLD;
                HOLD: if (evt.evt_ready && !found) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (loadable && found) begin
                out_key    <= sel;
                out_long   <= kind[sel];
                last_grant <= sel;
            end
        end
    end

    assign evt.evt_valid = (state == HOLD);
    assign evt.evt_key   = out_key;
    assign evt.evt_long  = out_long;
    assign evt.evt_drop  = drop_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: stimulus queues expected events, a monitor pops on accept.
module tb_key_event_scheduler;
    import bnw_pkg::*;

    localparam int N_KEYS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key_in = '0;

    key_event_if #(.N_KEYS(N_KEYS)) evt ();

    key_event_scheduler #(
        .N_KEYS (N_KEYS),
        .CNT_W  (8),
        .LONG_TH(100),
        .MIN_TH (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .evt   (evt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   drop_cnt = 0;
    evt_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input int key, input logic lng);
        evt_t e;
        e.key  = KEY_W_MAX'(key);
        e.long = lng;
        exp_q.push_back(e);
    endtask

    task automatic chk_out(input string name, input int key, input logic lng);
        chk({name, "_valid"}, 32'(evt.evt_valid), 32'd1);
        chk({name, "_key"},   32'(evt.evt_key),   32'(key));
        chk({name, "_long"},  32'(evt.evt_long),  32'(lng));
    endtask

    // Monitor: scoreboard pop on every accepted event, plus stability while stalled.
    initial begin
        logic       hold_prev;
        logic [2:0] key_prev;
        logic       long_prev;
        evt_t       e;
        hold_prev = 1'b0;
        key_prev  = '0;
        long_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (evt.evt_drop) drop_cnt++;
                if (hold_prev) begin
                    chk("stall_valid", 32'(evt.evt_valid), 32'd1);
                    chk("stall_key",   32'(evt.evt_key),   32'(key_prev));
                    chk("stall_long",  32'(evt.evt_long),  32'(long_prev));
                end
                if (evt.evt_valid && evt.evt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_evt got key %0d long %0d want none",
                                 evt.evt_key, evt.evt_long);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_key",  32'(evt.evt_key),  32'(e.key));
                        chk("sb_long", 32'(evt.evt_long), 32'(e.long));
                    end
                end
                hold_prev = evt.evt_valid && !evt.evt_ready;
                key_prev  = evt.evt_key;
                long_prev = evt.evt_long;
            end
        end
    end

    initial begin
        evt.evt_ready = 1'b1;
        tick(3);
        chk("rst_valid", 32'(evt.evt_valid), 32'd0);
        chk("rst_key",   32'(evt.evt_key),   32'd0);
        chk("rst_long",  32'(evt.evt_long),  32'd0);
        chk("rst_drop",  32'(evt.evt_drop),  32'd0);
        rst = 1'b0;
        tick(2);

        // Short press on key 2: valid two edges after the first low cycle.
        key_in[2] = 1'b1;
        tick(5);
        key_in[2] = 1'b0;
        expect_evt(2, EVT_SHORT);
        tick();
        chk("t1_lat", 32'(evt.evt_valid), 32'd0);
        tick();
        chk_out("t1", 2, EVT_SHORT);
        tick();
        chk("t1_single", 32'(evt.evt_valid), 32'd0);

        // Long hold on key 0 for 150 cycles: event during the hold, nothing on release.
        key_in[0] = 1'b1;
        tick(99);
        expect_evt(0, EVT_LONG);
        chk("t2_early", 32'(evt.evt_valid), 32'd0);
        tick();
        chk("t2_lat", 32'(evt.evt_valid), 32'd0);
        tick();
        chk_out("t2", 0, EVT_LONG);
        tick(49);
        key_in[0] = 1'b0;
        tick(6);

        // Glitch on key 5 shorter than MIN_TH.
        key_in[5] = 1'b1;
        tick();
        key_in[5] = 1'b0;
        tick(5);
        chk("t3_drop", 32'(drop_cnt), 32'd0);
        chk("t3_q", 32'(exp_q.size()), 32'd0);

        // Simultaneous release of 1, 3, 5 then round-robin ordering of 6 before 1.
        key_in = 8'b0010_1010;
        tick(4);
        key_in = '0;
        expect_evt(1, EVT_SHORT);
        expect_evt(3, EVT_SHORT);
        expect_evt(5, EVT_SHORT);
        tick();
        chk("t4_lat", 32'(evt.evt_valid), 32'd0);
        tick();
        chk_out("t4a", 1, EVT_SHORT);
        tick();
        chk_out("t4b", 3, EVT_SHORT);
        tick();
        chk_out("t4c", 5, EVT_SHORT);
        tick();
        chk("t4_idle", 32'(evt.evt_valid), 32'd0);
        key_in = 8'b0100_0010;
        tick(4);
        key_in = '0;
        expect_evt(6, EVT_SHORT);
        expect_evt(1, EVT_SHORT);
        tick(2);
        chk_out("t4d", 6, EVT_SHORT);
        tick();
        chk_out("t4e", 1, EVT_SHORT);
        tick(3);

        // Back-pressure: held output, pending slot, third press dropped.
        evt.evt_ready = 1'b0;
        key_in[4] = 1'b1;
        tick(3);
        key_in[4] = 1'b0;
        expect_evt(4, EVT_SHORT);
        tick(4);
        chk_out("t5_held", 4, EVT_SHORT);
        key_in[4] = 1'b1;
        tick(3);
        key_in[4] = 1'b0;
        expect_evt(4, EVT_SHORT);
        tick(3);
        key_in[4] = 1'b1;
        tick(3);
        key_in[4] = 1'b0;
        tick();
        chk("t5_drop_hi", 32'(evt.evt_drop), 32'd1);
        tick();
        chk("t5_drop_lo", 32'(evt.evt_drop), 32'd0);
        chk_out("t5_still", 4, EVT_SHORT);
        evt.evt_ready = 1'b1;
        tick(4);
        chk("t5_idle", 32'(evt.evt_valid), 32'd0);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t5_q", 32'(exp_q.size()), 32'd0);

        // Reset mid-press with an event held; key 7 restarts counting from zero.
        evt.evt_ready = 1'b0;
        key_in[3] = 1'b1;
        tick(3);
        key_in[3] = 1'b0;
        tick(3);
        chk_out("t6_held", 3, EVT_SHORT);
        key_in[7] = 1'b1;
        tick(60);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(evt.evt_valid), 32'd0);
        chk("t6_rst_key",   32'(evt.evt_key),   32'd0);
        chk("t6_rst_long",  32'(evt.evt_long),  32'd0);
        chk("t6_rst_drop",  32'(evt.evt_drop),  32'd0);
        tick(2);
        rst = 1'b0;
        evt.evt_ready = 1'b1;
        tick(99);
        chk("t6_early", 32'(evt.evt_valid), 32'd0);
        expect_evt(7, EVT_LONG);
        tick(2);
        chk_out("t6", 7, EVT_LONG);
        tick();
        key_in[7] = 1'b0;
        tick(5);
        chk("t6_q", 32'(exp_q.size()), 32'd0);
        chk("final_drop_cnt", 32'(drop_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
